// File: rtl/mem_pkg.sv
// Shared descriptor-memory types for the translator, scheduler and egress blocks.
package mem_pkg;

  localparam int ADDR_W = 10;

  typedef logic [ADDR_W-1:0] ptr_t;

endpackage

// File: rtl/egress_queue.sv
// One egress port: round-robin arbiter over all ingress requesters
// feeding a descriptor FIFO with a separately tracked occupancy count.
module egress_queue
  import mem_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0]                 ack_o,
  output logic                                 deq_valid_o,
  output logic [ADDR_W-1:0]                    deq_ptr_o,
  input  logic                                 deq_ready_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     count_o
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int IW = $clog2(QUEUE_DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  ptr_t                 mem_q [QUEUE_DEPTH];
  logic [IW-1:0]        wr_q, wr_d;
  logic [IW-1:0]        rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;

  logic [NUM_PORTS-1:0] elig;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        gnt;
  logic                 found;
  logic                 can_acc;
  logic                 enq;
  logic                 deq;

  // A requester stays high during its ack cycle, so mask it out.
  always_comb begin
    elig  = req_i & ~ack_q;
    idx   = '0;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PW'((int'(rr_q) + k) % NUM_PORTS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    can_acc = (cnt_q != FULL) || deq_ready_i;
    enq     = found && can_acc;
    deq     = (cnt_q != '0) && deq_ready_i;
    wr_d    = enq ? wr_q + 1'b1 : wr_q;
    rd_d    = deq ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rr_d  = rr_q;
    ack_d = '0;
    if (enq) begin
      rr_d       = (gnt == LAST) ? '0 : gnt + 1'b1;
      ack_d[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rr_q  <= '0;
      ack_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      ack_q <= ack_d;
    end
  end

  // Descriptor storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_q] <= ptr_i[gnt];
    end
  end

  assign ack_o       = ack_q;
  assign deq_valid_o = (cnt_q != '0);
  assign deq_ptr_o   = mem_q[rd_q];
  assign count_o     = cnt_q;

endmodule

// File: rtl/egress_scheduler.sv
// Per-egress arbitration of translator descriptor writes into egress queues;
// transposes ingress-major request buses into one queue instance per egress.
module egress_scheduler
  import mem_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0][ADDR_W-1:0]  ptr_i,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]              ack_o,
  output logic [NUM_PORTS-1:0]                             deq_valid_o,
  output logic [NUM_PORTS-1:0][ADDR_W-1:0]                 deq_ptr_o,
  input  logic [NUM_PORTS-1:0]                             deq_ready_i,
  output logic [NUM_PORTS-1:0][$clog2(QUEUE_DEPTH+1)-1:0]  count_o
);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             req_x;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             ack_x;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0][ADDR_W-1:0] ptr_x;

  for (genvar e = 0; e < NUM_PORTS; e++) begin : g_eg
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      assign req_x[e][i] = req_i[i][e];
      assign ptr_x[e][i] = ptr_i[i][e];
      assign ack_o[i][e] = ack_x[e][i];
    end

    egress_queue #(
      .NUM_PORTS   (NUM_PORTS),
      .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_x[e]),
      .ptr_i       (ptr_x[e]),
      .ack_o       (ack_x[e]),
      .deq_valid_o (deq_valid_o[e]),
      .deq_ptr_o   (deq_ptr_o[e]),
      .deq_ready_i (deq_ready_i[e]),
      .count_o     (count_o[e])
    );
  end

endmodule

// File: tb/tb_egress_scheduler.sv
// Bench for egress_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_egress_scheduler;
  import mem_pkg::*;

  localparam int NP = 4;
  localparam int QD = 8;
  localparam int AW = ADDR_W;

  logic                          clk;
  logic                          rst_n;
  logic [NP-1:0][NP-1:0]         req_i;
  logic [NP-1:0][NP-1:0][AW-1:0] ptr_i;
  logic [NP-1:0][NP-1:0]         ack_o;
  logic [NP-1:0]                 deq_valid_o;
  logic [NP-1:0][AW-1:0]         deq_ptr_o;
  logic [NP-1:0]                 deq_ready_i;
  logic [NP-1:0][3:0]            count_o;

  egress_scheduler #(.NUM_PORTS(NP), .QUEUE_DEPTH(QD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .ptr_i       (ptr_i),
    .ack_o       (ack_o),
    .deq_valid_o (deq_valid_o),
    .deq_ptr_o   (deq_ptr_o),
    .deq_ready_i (deq_ready_i),
    .count_o     (count_o)
  );

  // Reference model: one FIFO queue, rr pointer and ack set per egress.
  logic [AW-1:0] mq [NP][$];
  int            mrr [NP];
  bit            mack [NP][NP];

  // Requester state per (ingress, egress).
  bit            pend [NP][NP];
  bit            rel  [NP][NP];
  logic [AW-1:0] pptr [NP][NP];

  bit auto_new;
  bit chk_en;
  int pass_cnt;
  int total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void mreset();
    for (int e = 0; e < NP; e++) begin
      mq[e].delete();
      mrr[e] = 0;
      for (int i = 0; i < NP; i++) mack[i][e] = 1'b0;
    end
  endfunction

  function automatic void model_update();
    bit nack [NP][NP];
    int g;
    int j;
    bit dq;
    bit can;
    for (int e = 0; e < NP; e++) begin
      dq  = (mq[e].size() > 0) && deq_ready_i[e];
      can = (mq[e].size() < QD) || deq_ready_i[e];
      g   = -1;
      for (int k = 0; k < NP; k++) begin
        j = (mrr[e] + k) % NP;
        if (can && g < 0 && req_i[j][e] && !mack[j][e]) g = j;
      end
      for (int i = 0; i < NP; i++) nack[i][e] = 1'b0;
      if (dq) void'(mq[e].pop_front());
      if (g >= 0) begin
        mq[e].push_back(ptr_i[g][e]);
        nack[g][e] = 1'b1;
        mrr[e] = (g + 1) % NP;
      end
    end
    mack = nack;
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int e = 0; e < NP; e++) begin
        chk($sformatf("count[%0d]", e), 32'(count_o[e]),
            32'(mq[e].size()));
        chk($sformatf("valid[%0d]", e), 32'(deq_valid_o[e]),
            32'(mq[e].size() != 0));
        if (mq[e].size() != 0)
          chk($sformatf("head[%0d]", e), 32'(deq_ptr_o[e]),
              32'(mq[e][0]));
        for (int i = 0; i < NP; i++)
          chk($sformatf("ack[%0d][%0d]", i, e), 32'(ack_o[i][e]),
              32'(mack[i][e]));
      end
    end
  end

  task automatic cyc();
    for (int i = 0; i < NP; i++) begin
      for (int e = 0; e < NP; e++) begin
        if (pend[i][e] && mack[i][e]) begin
          rel[i][e] = 1'b1;
        end else if (rel[i][e]) begin
          rel[i][e]  = 1'b0;
          pend[i][e] = 1'b0;
          if (auto_new && $urandom_range(0, 1) == 1) begin
            pend[i][e] = 1'b1;
            pptr[i][e] = AW'($urandom);
          end
        end else if (!pend[i][e] && auto_new &&
                     $urandom_range(0, 3) == 0) begin
          pend[i][e] = 1'b1;
          pptr[i][e] = AW'($urandom);
        end
        req_i[i][e] = pend[i][e];
        ptr_i[i][e] = pptr[i][e];
      end
    end
    if (auto_new)
      for (int e = 0; e < NP; e++)
        deq_ready_i[e] = ($urandom_range(0, 2) == 0);
    model_update();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int e);
    deq_ready_i[e] = 1'b1;
    repeat (12) cyc();
    deq_ready_i[e] = 1'b0;
  endtask

  task automatic fill(input int e, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      pend[k % NP][e] = 1'b1;
      pptr[k % NP][e] = AW'(base + k);
      cyc();
      repeat (2) cyc();
    end
  endtask

  task automatic chk_reset_state(input string nm);
    for (int e = 0; e < NP; e++) begin
      chk({nm, "_count"}, 32'(count_o[e]), 32'd0);
      chk({nm, "_valid"}, 32'(deq_valid_o[e]), 32'd0);
    end
    chk({nm, "_acks"}, 32'(ack_o), 32'd0);
  endtask

  initial begin
    pass_cnt    = 0;
    total       = 0;
    auto_new    = 1'b0;
    chk_en      = 1'b0;
    rst_n       = 1'b1;
    req_i       = '0;
    ptr_i       = '0;
    deq_ready_i = '0;
    for (int i = 0; i < NP; i++)
      for (int e = 0; e < NP; e++) pptr[i][e] = '0;
    mreset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_state("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single request
    pend[1][2] = 1'b1;
    pptr[1][2] = 'h10;
    cyc();
    chk("single_ack", 32'(ack_o[1][2]), 32'd1);
    chk("single_valid", 32'(deq_valid_o[2]), 32'd1);
    chk("single_ptr", 32'(deq_ptr_o[2]), 32'h10);
    chk("single_count", 32'(count_o[2]), 32'd1);
    cyc();
    chk("single_pulse", 32'(ack_o[1][2]), 32'd0);
    drain(2);

    // Contention on egress 0 from rr=0
    pend[0][0] = 1'b1; pptr[0][0] = 'hA0;
    pend[2][0] = 1'b1; pptr[2][0] = 'hA2;
    pend[3][0] = 1'b1; pptr[3][0] = 'hA3;
    cyc();
    chk("cont_first", 32'(ack_o[0][0]), 32'd1);
    cyc();
    chk("cont_second", 32'(ack_o[2][0]), 32'd1);
    cyc();
    chk("cont_third", 32'(ack_o[3][0]), 32'd1);
    chk("cont_head", 32'(deq_ptr_o[0]), 32'hA0);
    chk("cont_count", 32'(count_o[0]), 32'd3);
    repeat (3) cyc();
    pend[0][0] = 1'b1; pptr[0][0] = 'hB0;
    cyc();
    repeat (2) cyc();
    pend[0][0] = 1'b1; pptr[0][0] = 'hC0;
    pend[1][0] = 1'b1; pptr[1][0] = 'hC1;
    cyc();
    chk("rr_ing1_wins", 32'(ack_o[1][0]), 32'd1);
    chk("rr_ing0_waits", 32'(ack_o[0][0]), 32'd0);
    cyc();
    chk("rr_ing0_next", 32'(ack_o[0][0]), 32'd1);
    repeat (2) cyc();
    drain(0);

    // Full queue on egress 1
    fill(1, QD, 'h50);
    chk("full_count", 32'(count_o[1]), 32'd8);
    pend[2][1] = 1'b1; pptr[2][1] = 'h5F;
    repeat (3) cyc();
    chk("full_held", 32'(ack_o[2][1]), 32'd0);
    chk("full_count_held", 32'(count_o[1]), 32'd8);
    deq_ready_i[1] = 1'b1;
    cyc();
    deq_ready_i[1] = 1'b0;
    chk("full_accept", 32'(ack_o[2][1]), 32'd1);
    chk("full_count_same", 32'(count_o[1]), 32'd8);
    chk("full_head", 32'(deq_ptr_o[1]), 32'h51);
    repeat (2) cyc();
    drain(1);

    // Flood from ingress 0 while egress 3 is full
    fill(3, QD, 'h60);
    chk("flood_full", 32'(count_o[3]), 32'd8);
    for (int e = 0; e < NP; e++) begin
      pend[0][e] = 1'b1;
      pptr[0][e] = 'h33;
    end
    cyc();
    chk("flood_ack0", 32'(ack_o[0][0]), 32'd1);
    chk("flood_ack1", 32'(ack_o[0][1]), 32'd1);
    chk("flood_ack2", 32'(ack_o[0][2]), 32'd1);
    chk("flood_ack3_held", 32'(ack_o[0][3]), 32'd0);
    repeat (2) cyc();
    chk("flood_ack3_still", 32'(ack_o[0][3]), 32'd0);
    deq_ready_i[3] = 1'b1;
    cyc();
    deq_ready_i[3] = 1'b0;
    chk("flood_ack3", 32'(ack_o[0][3]), 32'd1);
    chk("flood_count3", 32'(count_o[3]), 32'd8);
    repeat (2) cyc();
    chk("flood_no_dup", 32'(count_o[0]), 32'd1);
    drain(0);
    drain(1);
    drain(2);

    // Wrap-around through egress 2
    deq_ready_i[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pend[k % NP][2] = 1'b1;
      pptr[k % NP][2] = AW'('h100 + k);
      cyc();
      chk("wrap_order", 32'(deq_ptr_o[2]), 32'('h100 + k));
      chk("wrap_count", 32'(count_o[2]), 32'd1);
    end
    drain(2);

    // Reset mid-operation
    fill(0, 5, 'h20);
    chk("mid_count", 32'(count_o[0]), 32'd5);
    pend[2][3] = 1'b1; pptr[2][3] = 'h77;
    repeat (2) cyc();
    chk("mid_pending", 32'(ack_o[2][3]), 32'd0);
    rst_n = 1'b0;
    mreset();
    #1;
    chk_reset_state("mid_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("post_reset_ack", 32'(ack_o[2][3]), 32'd1);
    chk("post_reset_ptr", 32'(deq_ptr_o[3]), 32'h77);
    chk("post_reset_count", 32'(count_o[3]), 32'd1);
    repeat (3) cyc();
    drain(3);

    // Randomized soak
    auto_new = 1'b1;
    repeat (3000) cyc();
    auto_new    = 1'b0;
    deq_ready_i = '1;
    repeat (30) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/egress_scheduler.md
# egress_scheduler

Arbitrates frame-descriptor write requests from the per-ingress translators onto each egress port and buffers the accepted start pointers in one descriptor queue per egress port. It sits between the translators and the egress readers. Each egress port has an independent round-robin arbiter over all ingress ports. Flooded frames are accepted independently per egress port.

## Interface
- `NUM_PORTS`, default 4: number of ingress ports and number of egress ports.
- `QUEUE_DEPTH`, default 8: descriptors per egress queue; must be a power of 2 and at least 2.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_i`  in  `[NUM_PORTS-1:0][NUM_PORTS-1:0]`: `req_i[i][e]` means ingress `i` requests enqueue to egress `e`.
- `ptr_i`  in  `[NUM_PORTS-1:0][NUM_PORTS-1:0][ADDR_W-1:0]`: start pointer for `req_i[i][e]`.
- `ack_o`  out  `[NUM_PORTS-1:0][NUM_PORTS-1:0]`: one-cycle pulse meaning `req_i[i][e]` was accepted at the previous edge.
- `deq_valid_o`  out  `[NUM_PORTS-1:0]`: egress queue `e` is non-empty.
- `deq_ptr_o`  out  `[NUM_PORTS-1:0][ADDR_W-1:0]`: head descriptor of queue `e`.
- `deq_ready_i`  in  `[NUM_PORTS-1:0]`: egress `e` consumes the head this cycle.
- `count_o`  out  `[NUM_PORTS-1:0][$clog2(QUEUE_DEPTH+1)-1:0]`: occupancy of queue `e`.

## Operation
- **Requester contract.**
  - A requester holds `req_i[i][e]` high with `ptr_i[i][e]` stable until it sees `ack_o[i][e]`.
  - It then drops the request, or presents a new descriptor, no earlier than the following edge.
- **Eligibility.** Per egress `e`, ingress `i` is eligible when `req_i[i][e]=1` and `ack_o[i][e]=0`. The ack mask prevents a double accept while the requester reacts.
- **Accept condition.** Queue `e` can accept when `count<QUEUE_DEPTH`, or when `count==QUEUE_DEPTH` and `deq_ready_i[e]` is high in the same cycle.
- **Grant.** When queue `e` can accept and at least one ingress is eligible, the grant goes to the first eligible ingress found scanning from `rr[e]` upward, modulo `NUM_PORTS`.
- **On a grant to ingress `g`:**
  - write `ptr_i[g][e]` at the write index;
  - advance the write index;
  - set `ack_o[g][e]` at the edge;
  - set `rr[e] <= (g+1) mod NUM_PORTS`.
- **No grant.** `rr[e]` is unchanged and no ack is issued.
- **Dequeue.** `deq_valid_o[e] = (count!=0)` and `deq_ptr_o[e] = mem[rd_idx]`. When valid and ready are both high, `rd_idx` advances. `deq_ready_i` is ignored when the queue is empty.
- **Occupancy arithmetic.**
  - Read and write indexes are `$clog2(QUEUE_DEPTH)` bits wide and wrap naturally.
  - `count` is tracked separately: +1 on enqueue only, −1 on dequeue only, unchanged when both occur.
- **Independence.** Egress ports are fully independent. A flooding ingress may be acked by different egress ports in different cycles.
- **Reset.** Asserting `rst_n` low at any time flushes all queues: counts, indexes and `rr` go to 0 and all acks clear. Queue memory contents are not reset.

## Timing
- Reset values:
  - `ack_o` = 0, `deq_valid_o` = 0, `count_o` = 0;
  - `deq_ptr_o` is don't-care while valid is 0.
- Request-to-data latency: a request eligible in cycle N with space available gives `ack_o` high in N+1. The descriptor is visible at `deq_ptr_o` in N+1 if the queue was empty.
- `ack_o` is registered and lasts exactly one cycle per accept.
- `deq_valid_o`, `deq_ptr_o` and `count_o` are all registered-state derived, with no combinational path from `req_i`.
- A full queue with a simultaneous dequeue accepts in that same cycle and `count` stays at `QUEUE_DEPTH`.
- Throughput: one enqueue and one dequeue per egress per cycle.

## Structure
- `mem_pkg` supplies `ADDR_W`. Add `ptr_t` (`logic [ADDR_W-1:0]`) there for reuse by the translator and egress blocks.
- Sub-module `egress_queue`: one instance per egress, containing the round-robin arbiter, the FIFO and the count. The top module is a generate loop plus transposition of `req_i`/`ptr_i`/`ack_o`.

## Test plan
- **Single request.** Reset; ingress 1 requests egress 2 with ptr 0x10 → `ack_o[1][2]` pulses one cycle later; `deq_valid_o[2]=1`, `deq_ptr_o[2]=0x10`, `count_o[2]=1`.
- **Contention.** Ingress 0, 2 and 3 all hold requests to egress 0 with ptrs 0xA0, 0xA2, 0xA3, and `rr=0` → accepted order 0xA0, 0xA2, 0xA3 over three consecutive cycles. A later request from ingress 0 loses to a pending ingress 1.
- **Full queue.** Fill egress 1 to 8 entries with `deq_ready_i=0`; a ninth request is held with no ack and `count_o[1]=8`. Raise `deq_ready_i[1]` for one cycle → the ninth is accepted in that cycle and count stays 8.
- **Flood.** Ingress 0 requests all 4 egress ports with ptr 0x33 while egress 3 is full → acks for egress 0, 1 and 2 arrive in the next cycle. Egress 3 acks only after a dequeue; no duplicate entries appear.
- **Wrap-around.** Run 20 enqueue/dequeue pairs through one queue with incrementing pointers → dequeue order is exactly in order and `count` never exceeds 8.
- **Reset mid-operation.** Assert `rst_n` low mid-operation with 5 entries queued and a request pending → all counts, valids and acks are 0 immediately. After release, the pending request is acked.
